// File: rtl/sqrt_arbiter_pkg.sv
// Shared types and helpers for the round-robin square-root arbiter.
package sqrt_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        DONE
    } state_t;

    // Root width for a given radical width; odd widths are padded by one MSB.
    function automatic int qw_of(input int width);
        return (width + 1) / 2;
    endfunction

endpackage

// File: rtl/sqrt_iter_core.sv
// Iterative restoring square-root datapath: one result bit per advance.
// q/rem present the outcome of the step that the next advance will commit.
module sqrt_iter_core
    import sqrt_arbiter_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int QW    = qw_of(WIDTH)
) (
    input  logic             clk,
    input  logic             aclr,
    input  logic             load,
    input  logic [WIDTH-1:0] radical,
    input  logic             advance,
    output logic [QW-1:0]    q,
    output logic [QW:0]      rem,
    output logic             last
);

    localparam int RW = 2 * QW;
    localparam int SW = (QW > 1) ? $clog2(QW) : 1;

    logic [RW-1:0] rad_reg;
    logic [QW+1:0] r_reg;
    logic [QW+1:0] r_shift;
    logic [QW+1:0] t;
    logic [QW+1:0] r_next;
    logic [QW-1:0] q_reg;
    logic [QW-1:0] q_next;
    logic [SW-1:0] step;

    always_comb begin
        r_shift = (r_reg << 2) | {{QW{1'b0}}, rad_reg[RW-1 -: 2]};
        t       = {q_reg, 2'b01};
        if (r_shift >= t) begin
            r_next = r_shift - t;
            q_next = (q_reg << 1) | QW'(1);
        end else begin
            r_next = r_shift;
            q_next = q_reg << 1;
        end
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            rad_reg <= '0;
            r_reg   <= '0;
            q_reg   <= '0;
            step    <= '0;
        end else if (load) begin
            rad_reg <= RW'(radical);
            r_reg   <= '0;
            q_reg   <= '0;
            step    <= SW'(QW - 1);
        end else if (advance) begin
            rad_reg <= rad_reg << 2;
            r_reg   <= r_next;
            q_reg   <= q_next;
            step    <= step - SW'(1);
        end
    end

    assign q    = q_next;
    assign rem  = r_next[QW:0];
    assign last = (step == '0);

endmodule

// File: rtl/sqrt_arbiter.sv
// Round-robin arbiter sharing one iterative square-root engine between
// NREQ requesters, with a single tagged valid/ready response port.
module sqrt_arbiter
    import sqrt_arbiter_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = 16,
    localparam int QW    = qw_of(WIDTH),
    localparam int IW    = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  aclr,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_radical,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IW-1:0]         rsp_id,
    output logic [QW-1:0]         rsp_q,
    output logic [QW:0]           rsp_rem,
    output logic                  busy
);

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   id_reg;
    logic [IW-1:0]   grant_idx;
    logic [IW-1:0]   cand;
    logic            grant_found;
    logic            grant;
    logic [QW-1:0]   core_q;
    logic [QW:0]     core_rem;
    logic            core_last;

    // Search starts just after the last winner so every requester gets a turn.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(ptr) + k) % NREQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign grant = (state == IDLE) && grant_found;

    always_comb begin
        req_ready = '0;
        if (grant && !aclr) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    sqrt_iter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk     (clk),
        .aclr    (aclr),
        .load    (grant),
        .radical (req_radical[grant_idx*WIDTH +: WIDTH]),
        .advance (state == ITER),
        .q       (core_q),
        .rem     (core_rem),
        .last    (core_last)
    );

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state     <= IDLE;
            ptr       <= IW'(NREQ - 1);
            id_reg    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_q     <= '0;
            rsp_rem   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        ptr    <= grant_idx;
                        id_reg <= grant_idx;
                        state  <= ITER;
                    end
                end
                ITER: begin
                    if (core_last) begin
                        rsp_q     <= core_q;
                        rsp_rem   <= core_rem;
                        rsp_id    <= id_reg;
                        rsp_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Self-checking bench for sqrt_arbiter: scoreboard of expected roots plus
// per-scenario tasks for arbitration order, timing, stalls and reset abort.
module tb_sqrt_arbiter;

    logic        clk = 1'b0;
    logic        aclr;
    logic [3:0]  req_valid;
    logic [63:0] req_radical;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_q;
    logic [8:0]  rsp_rem;
    logic        busy;

    logic [1:0]  v7;
    logic [13:0] rad7;
    logic [1:0]  rdy7;
    logic        rv7;
    logic        rr7;
    logic        id7;
    logic [3:0]  q7;
    logic [4:0]  rem7;
    logic        busy7;

    typedef struct {
        int id;
        int q;
        int rem;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    sqrt_arbiter #(.NREQ(4), .WIDTH(16)) dut (
        .clk         (clk),
        .aclr        (aclr),
        .req_valid   (req_valid),
        .req_radical (req_radical),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_q       (rsp_q),
        .rsp_rem     (rsp_rem),
        .busy        (busy)
    );

    sqrt_arbiter #(.NREQ(2), .WIDTH(7)) dut7 (
        .clk         (clk),
        .aclr        (aclr),
        .req_valid   (v7),
        .req_radical (rad7),
        .req_ready   (rdy7),
        .rsp_valid   (rv7),
        .rsp_ready   (rr7),
        .rsp_id      (id7),
        .rsp_q       (q7),
        .rsp_rem     (rem7),
        .busy        (busy7)
    );

    function automatic int isqrt(input int rad);
        int q;
        q = 0;
        while ((q + 1) * (q + 1) <= rad) q++;
        return q;
    endfunction

    // Scoreboard: push on each accept, pop on each response transfer.
    always @(negedge clk) begin : monitor
        exp_t e;
        exp_t got;
        int   r;
        if (!aclr) begin
            if (req_ready != 4'b0000) begin
                checks++;
                if ($countones(req_ready) != 1) begin
                    errors++;
                    $display("[TB] FAIL onehot: req_ready=%b required one-hot", req_ready);
                end
                for (int i = 0; i < 4; i++) begin
                    if (req_ready[i]) begin
                        r     = int'(req_radical[i*16 +: 16]);
                        e.id  = i;
                        e.q   = isqrt(r);
                        e.rem = r - e.q * e.q;
                        sb.push_back(e);
                    end
                end
            end
            if (rsp_valid && rsp_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_rsp: id=%0d q=%0d rem=%0d with empty scoreboard",
                             rsp_id, rsp_q, rsp_rem);
                end else begin
                    e     = sb.pop_front();
                    got.id  = int'(rsp_id);
                    got.q   = int'(rsp_q);
                    got.rem = int'(rsp_rem);
                    if (got.id !== e.id || got.q !== e.q || got.rem !== e.rem) begin
                        errors++;
                        $display("[TB] FAIL rsp: got id=%0d q=%0d rem=%0d required id=%0d q=%0d rem=%0d",
                                 got.id, got.q, got.rem, e.id, e.q, e.rem);
                    end
                end
            end
        end
    end

    task automatic wait_grant(output int idx);
        int n;
        idx = -1;
        n   = 0;
        while (idx < 0 && n < 60) begin
            @(negedge clk);
            n++;
            for (int i = 0; i < 4; i++) if (req_ready[i]) idx = i;
        end
        if (idx < 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL grant_timeout: no req_ready within %0d cycles", n);
        end
    endtask

    task automatic accept_drop(input int idx);
        @(posedge clk);
        #1;
        if (idx >= 0) req_valid[idx] = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0 || busy) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: pending=%0d busy=%b required 0/0", sb.size(), busy);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        aclr = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        aclr = 1'b0;
    endtask

    task automatic send_one(input int idx, input int rad);
        int g;
        @(posedge clk);
        #1;
        req_radical[idx*16 +: 16] = 16'(rad);
        req_valid[idx] = 1'b1;
        wait_grant(g);
        checks++;
        if (g !== idx) begin
            errors++;
            $display("[TB] FAIL send_grant: got %0d required %0d", g, idx);
        end
        accept_drop(idx);
        wait_drain();
    endtask

    task automatic test_reset();
        aclr        = 1'b1;
        req_valid   = 4'hF;
        req_radical = '0;
        rsp_ready   = 1'b1;
        v7 = 2'b00; rad7 = '0; rr7 = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_req_ready: got %b required 0000", req_ready);
        end
        checks++;
        if ({rsp_valid, rsp_id, rsp_q, rsp_rem, busy} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: valid=%b id=%0d q=%0d rem=%0d busy=%b required all 0",
                     rsp_valid, rsp_id, rsp_q, rsp_rem, busy);
        end
        req_valid = 4'h0;
        @(posedge clk);
        #1;
        aclr = 1'b0;
    endtask

    task automatic test_single();
        int g;
        int n;
        int pulses;
        bit done;
        @(posedge clk);
        #1;
        req_radical[15:0] = 16'd144;
        req_valid[0] = 1'b1;
        wait_grant(g);
        checks++;
        if (g !== 0) begin
            errors++;
            $display("[TB] FAIL single_grant: got %0d required 0", g);
        end
        accept_drop(0);
        n = 0; pulses = 0; done = 0;
        while (!done && n < 40) begin
            @(posedge clk);
            n++;
            #1;
            if (req_ready != 4'b0000) pulses++;
            if (rsp_valid) done = 1;
        end
        checks++;
        if (n !== 8 || pulses !== 0) begin
            errors++;
            $display("[TB] FAIL single_latency: got %0d edges, %0d extra grants required 8 and 0",
                     n, pulses);
        end
        wait_drain();
    endtask

    task automatic test_max_zero();
        send_one(3, 65535);
        send_one(0, 0);
        send_one(2, 65534);
    endtask

    task automatic test_all_four();
        int g;
        do_reset();
        req_radical = {16'd3, 16'd2, 16'd1, 16'd0};
        req_valid   = 4'hF;
        for (int k = 0; k < 4; k++) begin
            wait_grant(g);
            checks++;
            if (g !== k) begin
                errors++;
                $display("[TB] FAIL all_four_order: grant %0d got %0d required %0d", k, g, k);
            end
            accept_drop(g);
        end
        wait_drain();
    endtask

    task automatic test_alternate();
        int g;
        int n;
        logic [7:0] sq;
        logic [8:0] srem;
        logic [1:0] sid;
        do_reset();
        rsp_ready = 1'b0;
        req_radical[15:0]  = 16'd100;
        req_radical[47:32] = 16'd200;
        req_valid = 4'b0101;
        wait_grant(g);
        checks++;
        if (g !== 0) begin
            errors++;
            $display("[TB] FAIL alt_first: got %0d required 0", g);
        end
        n = 0;
        while (!rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        sq = rsp_q; srem = rsp_rem; sid = rsp_id;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (!rsp_valid || rsp_q !== sq || rsp_rem !== srem || rsp_id !== sid ||
                req_ready !== 4'b0000) begin
                errors++;
                $display("[TB] FAIL stall_hold: cycle %0d valid=%b q=%0d rem=%0d id=%0d ready=%b required 1/%0d/%0d/%0d/0000",
                         c, rsp_valid, rsp_q, rsp_rem, rsp_id, req_ready, sq, srem, sid);
            end
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            wait_grant(g);
            checks++;
            if (g !== ((k % 2 == 1) ? 2 : 0)) begin
                errors++;
                $display("[TB] FAIL alt_order: grant %0d got %0d required %0d",
                         k, g, (k % 2 == 1) ? 2 : 0);
            end
        end
        @(posedge clk);
        #1;
        req_valid = 4'b0000;
        wait_drain();
    endtask

    task automatic test_width7();
        int n;
        @(posedge clk);
        #1;
        rad7[6:0] = 7'd127;
        v7[0] = 1'b1;
        n = 0;
        while (rdy7 !== 2'b01 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        v7[0] = 1'b0;
        n = 0;
        while (!rv7 && n < 20) begin
            @(posedge clk);
            n++;
            #1;
        end
        checks++;
        if (n !== 4 || q7 !== 4'd11 || rem7 !== 5'd6 || id7 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL width7: got edges=%0d q=%0d rem=%0d id=%0d required 4/11/6/0",
                     n, q7, rem7, id7);
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic test_reset_abort();
        int  g;
        bit  seen;
        @(posedge clk);
        #1;
        req_radical[31:16] = 16'd50;
        req_valid[1] = 1'b1;
        wait_grant(g);
        accept_drop(g);
        repeat (3) @(posedge clk);
        #1;
        aclr = 1'b1;
        sb.delete();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_in_reset: valid=%b busy=%b required 0/0", rsp_valid, busy);
        end
        @(posedge clk);
        #1;
        aclr = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid) seen = 1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_result: rsp_valid seen after abort, required never");
        end
        @(posedge clk);
        #1;
        req_radical[15:0]  = 16'd9;
        req_radical[31:16] = 16'd16;
        req_valid = 4'b0011;
        wait_grant(g);
        checks++;
        if (g !== 0) begin
            errors++;
            $display("[TB] FAIL abort_restart: got %0d required 0", g);
        end
        accept_drop(g);
        wait_grant(g);
        accept_drop(g);
        wait_drain();
    endtask

    task automatic test_random();
        int g;
        for (int round = 0; round < 6; round++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) req_radical[i*16 +: 16] = 16'($urandom_range(0, 65535));
            req_valid = 4'hF;
            for (int k = 0; k < 4; k++) begin
                wait_grant(g);
                accept_drop(g);
            end
            wait_drain();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_max_zero();
        test_all_four();
        test_alternate();
        test_width7();
        test_reset_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
